// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width, boot-loader framing constants and loader state encoding.
package cpu_pkg;

  localparam int WORD_W           = 32;
  localparam int LOADER_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD   = 4;
  localparam int LOADER_LEN_W     = LOADER_HDR_BYTES * 8;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_HDR_HI  = 3'd1,
    LD_HDR_LO  = 3'd2,
    LD_PAYLOAD = 3'd3,
    LD_WRITE   = 3'd4,
    LD_CHECK   = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERR     = 3'd7
  } loader_state_e;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register; word_ready flags the byte that completes a word.
module word_assembler
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] word_reg;
  logic [IDX_W-1:0]  idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (clr) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (shift_en) begin
      word_reg <= {word_reg[WORD_W-9:0], byte_in};
      idx_reg  <= idx_reg + 1'b1;
    end
  end

  assign word       = word_reg;
  assign word_ready = shift_en && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit memory writes, then releases the CPU.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_STEP = 4,
  parameter int          MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [15:0]       word_count,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_e FINISH_ST = LD_CHECK;
`else
  localparam loader_state_e FINISH_ST = LD_DONE;
`endif
  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  loader_state_e           state_reg, state_next;
  logic [LOADER_LEN_W-1:0] len_reg;
  logic [31:0]             addr_reg;
  logic [15:0]             count_reg;

  logic                    accept;
  logic                    start_load;
  logic                    shift_en;
  logic                    word_ready;
  logic [LOADER_LEN_W-1:0] hdr_len;
  logic [15:0]             count_inc;

  assign accept     = byte_valid && byte_ready;
  assign start_load = start && (state_reg == LD_IDLE || state_reg == LD_DONE || state_reg == LD_ERR);
  assign shift_en   = accept && (state_reg == LD_PAYLOAD);
  assign hdr_len    = {len_reg[LOADER_LEN_W-1:8], byte_in};
  assign count_inc  = count_reg + 16'd1;

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_load),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .word      (mem_wdata),
    .word_ready(word_ready)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xor_reg;

  // Running XOR covers header and payload bytes; the checksum byte itself is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_reg <= 8'h00;
    end else if (start_load) begin
      xor_reg <= 8'h00;
    end else if (accept && state_reg != LD_CHECK) begin
      xor_reg <= xor_reg ^ byte_in;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) state_next = LD_HDR_HI;
      end
      LD_HDR_HI: begin
        if (accept) state_next = LD_HDR_LO;
      end
      LD_HDR_LO: begin
        if (accept) begin
          if (hdr_len == '0)                 state_next = FINISH_ST;
          else if (32'(hdr_len) > MAX_LEN)   state_next = LD_ERR;
          else                               state_next = LD_PAYLOAD;
        end
      end
      LD_PAYLOAD: begin
        if (word_ready) state_next = LD_WRITE;
      end
      LD_WRITE: begin
        state_next = (count_inc == len_reg) ? FINISH_ST : LD_PAYLOAD;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (accept) state_next = (xor_reg == byte_in) ? LD_DONE : LD_ERR;
      end
`endif
      default: state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LD_IDLE;
      len_reg   <= '0;
      addr_reg  <= BASE_ADDR;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (start_load) begin
        len_reg   <= '0;
        addr_reg  <= BASE_ADDR;
        count_reg <= 16'd0;
      end else begin
        if (accept && state_reg == LD_HDR_HI) len_reg[LOADER_LEN_W-1:8] <= byte_in;
        if (accept && state_reg == LD_HDR_LO) len_reg <= hdr_len;
        // Address and count advance as the write cycle retires; the address wraps naturally.
        if (state_reg == LD_WRITE) begin
          addr_reg  <= addr_reg + 32'(ADDR_STEP);
          count_reg <= count_inc;
        end
      end
    end
  end

  assign byte_ready = (state_reg == LD_HDR_HI) || (state_reg == LD_HDR_LO) ||
                      (state_reg == LD_PAYLOAD) || (state_reg == LD_CHECK);
  assign mem_we     = (state_reg == LD_WRITE);
  assign mem_addr   = addr_reg;
  assign word_count = count_reg;
  assign done       = (state_reg == LD_DONE);
  assign cpu_run    = (state_reg == LD_DONE);
  assign error      = (state_reg == LD_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected memory writes plus status checks.
module tb_program_loader;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] word_count;
  logic        cpu_run;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[0:7];

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(32'h0), .ADDR_STEP(4), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .cpu_run(cpu_run), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      logic [63:0] e;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
        $display("write addr=%h data=%h (expected %h/%h)", mem_addr, mem_wdata, e[63:32], e[31:0]);
      end
      chk("wr_byte_ready", 32'(byte_ready), 32'd0);
      chk("wr_cpu_run", 32'(cpu_run), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    byte_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends header + up to 'limit' payload bytes; queues each word that will be fully sent.
  task automatic send_image(input int n, input bit gaps, input int limit, input bit bad_cs);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    logic [15:0] len = 16'(n);
    int sent = 0;
    send_byte(len[15:8], gaps); x ^= len[15:8];
    send_byte(len[7:0], gaps);  x ^= len[7:0];
    if (n > MAXW) return;
    for (int i = 0; i < n; i++) begin
      if ((i + 1) * 4 <= limit) exp_q.push_back({32'(i * 4), img[i]});
      for (int k = 3; k >= 0; k--) begin
        if (sent >= limit) return;
        b = img[i][k*8 +: 8];
        send_byte(b, gaps);
        x ^= b;
        sent++;
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_cs ? ~x : x, gaps);
`else
    if (bad_cs) $display("checksum feature disabled, no trailing byte");
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic load: 2 words, no gaps
    img[0] = 32'h2002_000A; img[1] = 32'h0000_0008;
    pulse_start();
    chk("hdr_byte_ready", 32'(byte_ready), 32'd1);
    send_image(2, 1'b0, 8, 1'b0);
    wait_end();
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_cpu_run", 32'(cpu_run), 32'd1);
    chk("basic_error", 32'(error), 32'd0);
    chk("basic_count", 32'(word_count), 32'd2);
    chk("basic_addr", mem_addr, 32'h8);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("basic load: done=%b cpu_run=%b count=%0d", done, cpu_run, word_count);

    // Zero length, started from DONE
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_run_clr", 32'(cpu_run), 32'd0);
    chk("restart_count_clr", 32'(word_count), 32'd0);
    send_image(0, 1'b0, 0, 1'b0);
    wait_end();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_run", 32'(cpu_run), 32'd1);
    chk("zero_count", 32'(word_count), 32'd0);
    $display("zero length: done=%b cpu_run=%b", done, cpu_run);

    // Oversize header
    pulse_start();
    send_image(MAXW + 1, 1'b0, 0, 1'b0);
    wait_end();
    chk("over_error", 32'(error), 32'd1);
    chk("over_done", 32'(done), 32'd0);
    chk("over_cpu_run", 32'(cpu_run), 32'd0);
    chk("over_byte_ready", 32'(byte_ready), 32'd0);
    $display("oversize: error=%b cpu_run=%b", error, cpu_run);

    // Bubbles, 3 random words, started from ERR
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    pulse_start();
    chk("restart_err_clr", 32'(error), 32'd0);
    send_image(3, 1'b1, 12, 1'b0);
    wait_end();
    chk("gaps_done", 32'(done), 32'd1);
    chk("gaps_count", 32'(word_count), 32'd3);
    chk("gaps_addr", mem_addr, 32'hC);
    chk("gaps_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("bubbles: done=%b count=%0d", done, word_count);

    // Reset after 6 payload bytes, asserted between clock edges
    img[0] = 32'hA1B2_C3D4; img[1] = 32'h5566_7788; img[2] = 32'h99AA_BBCC;
    pulse_start();
    send_image(3, 1'b0, 6, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    $display("mid-load reset: byte_ready=%b word_count=%0d", byte_ready, word_count);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    img[0] = 32'hDEAD_BEEF; img[1] = 32'h0BAD_F00D;
    pulse_start();
    send_image(2, 1'b1, 8, 1'b0);
    wait_end();
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_count", 32'(word_count), 32'd2);
    chk("reload_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("reload after reset: done=%b count=%0d", done, word_count);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img[0] = 32'h1234_5678;
    pulse_start();
    exp_q.push_back({32'h0, 32'h1234_5678});
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    send_byte(8'h09, 1'b0);
    wait_end();
    chk("cs_good_done", 32'(done), 32'd1);
    chk("cs_good_run", 32'(cpu_run), 32'd1);
    $display("checksum good: done=%b", done);
    pulse_start();
    exp_q.push_back({32'h0, 32'h1234_5678});
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0); send_byte(8'h78, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    chk("cs_bad_error", 32'(error), 32'd1);
    chk("cs_bad_run", 32'(cpu_run), 32'd0);
    chk("cs_bad_count", 32'(word_count), 32'd1);
    chk("cs_bad_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("checksum bad: error=%b cpu_run=%b", error, cpu_run);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
